imem_fetch_port: RTL and testbench
==================================

// Module: imem_fetch_port
// PURPOSE
//  Parametrised instruction memory with a fetch handshake, replacing the fixed 32x32 instruction array.
//  Holds DEPTH instruction words and clears itself to NOP after reset.
//  Accepts program loads from the testbench/loader port.
//  Serves fetch requests from the PC stage with 1-cycle registered latency, a ready/valid handshake and fault reporting.
// PARAMETERS
//  XLEN      32           instruction/PC width
//  DEPTH     64           number of instruction words (power of 2, >=4)
//  ADDR_W    $clog2(DEPTH) word-index width (derived, not overridden)
//  INIT_WORD 32'h00000013 fill value after reset (RV32I NOP: addi x0,x0,0)
// PORTS
//  clk         in   1      rising-edge clock
//  reset       in   1      reset, synchronous, active-high
//  init_done   out  1      1 once the post-reset clear has finished
//  prog_we     in   1      program-load write strobe
//  prog_addr   in   ADDR_W word index to write
//  prog_data   in   XLEN   instruction word to write
//  req_valid   in   1      fetch request valid
//  req_ready   out  1      fetch request accepted when valid&ready
//  req_pc      in   XLEN   byte address of the requested instruction
//  rsp_valid   out  1      response valid
//  rsp_ready   in   1      consumer accepts the response
//  rsp_instr   out  XLEN   fetched word (INIT_WORD on fault)
//  rsp_fault   out  2      00 ok, 01 misaligned, 10 out-of-range
// BEHAVIOUR
//  Reset values: init_done=0, rsp_valid=0, rsp_instr=0, rsp_fault=00, req_ready=0, FSM=S_INIT, clr_cnt=0.
//  FSM S_INIT:
//   - Writes INIT_WORD to word clr_cnt on every cycle, then increments clr_cnt.
//   - Moves to S_RUN after writing word DEPTH-1, so the clear takes exactly DEPTH cycles.
//   - prog_we and req_valid are ignored in this state.
//  FSM S_RUN: init_done=1. There is no exit except reset.
//  Reset asserted in any state (including mid-clear or with rsp pending):
//   - Next cycle is S_INIT with clr_cnt=0.
//   - Any pending response is dropped.
//  req_ready = (S_RUN) & !prog_we & (!rsp_valid | rsp_ready). This is combinational.
//  Program load: in S_RUN with prog_we=1, mem[prog_addr] <= prog_data.
//   - The load takes priority over a fetch in the same cycle: req_ready=0 and the fetch is stalled.
//  Fetch accepted at edge N: rsp_valid=1 with the result from edge N+1 (latency 1).
//   - Word index = req_pc[ADDR_W+1:2].
//   - If req_pc[1:0]!=0: rsp_fault=01, rsp_instr=INIT_WORD. Misaligned takes priority over range.
//   - Else if req_pc[XLEN-1:ADDR_W+2]!=0: rsp_fault=10, rsp_instr=INIT_WORD.
//   - Else: rsp_fault=00, rsp_instr=mem[index].
//  Backpressure: while rsp_valid & !rsp_ready, rsp_instr and rsp_fault are held stable and no new fetch is accepted.
//  Back-to-back: with rsp_ready=1 and req_valid=1 held, the port returns one response per cycle.
//  rsp_valid falls when rsp_ready=1 and no new request is accepted in that cycle.
//  Read-after-load: a load at edge N is visible to a fetch accepted at edge N+1.
//  No address wrap: a PC beyond DEPTH*4-1 always faults and never aliases.
// STRUCTURE
//  Shared package riscv_pkg:
//   - localparam RV_NOP = 32'h00000013.
//   - typedef enum logic[1:0] {FAULT_NONE, FAULT_MISALIGN, FAULT_RANGE} imem_fault_t.
//   - typedef enum logic {S_INIT, S_RUN} imem_state_t.
//  Sub-module imem_sram (single-port, sync write, sync read, DEPTH x XLEN):
//   - Writes come from the clear counter or the load port.
//   - Reads come from the fetch.
//   - Reads and writes never occur in the same cycle, by construction of req_ready.
//  The top level holds the FSM, clear counter, fault decode and the response register.
// TESTING
//  1 Reset, DEPTH=64 -> init_done rises exactly 64 cycles after reset falls; fetch pc=0x0FC -> instr=0x00000013, fault=00.
//  2 Load addr 3 = 0x00500093, then fetch pc=0x00C next cycle -> instr=0x00500093, fault=00, rsp_valid 1 cycle after accept.
//  3 Fetch pc=0x006 -> fault=01, instr=0x00000013; fetch pc=0x100 (DEPTH=64) -> fault=10; fetch pc=0x102 -> fault=01.
//  4 Stream pc=0,4,8,C with rsp_ready=0 for 3 cycles mid-stream -> rsp held stable, req_ready=0; all 4 words in order, none lost or duplicated.
//  5 prog_we=1 with req_valid=1 in the same cycle -> req_ready=0, load done, fetch served next cycle with the new data.
//  6 Reset mid-clear (cycle 20) and with rsp pending -> rsp_valid=0 next cycle; clear restarts and takes the full 64 cycles.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: NOP encoding, fetch fault codes and the
// instruction-memory controller states.
package riscv_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10
  } imem_fault_t;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } imem_state_t;

endpackage

// File: rtl/imem_sram.sv
// Single-port DEPTH x XLEN instruction array with synchronous write and
// synchronous (registered) read. The caller never asserts we and re together.
module imem_sram #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  // Array write port.
  // NOTE: the storage array has no reset term; it is filled word by word by
  // the controller's clear sequence, which keeps it mappable onto RAM macros.
  // Sequential state is always updated with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Registered read port; holds its value between reads so the response
  // stays stable under backpressure.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/imem_fetch_port.sv
// Instruction memory with post-reset clear to NOP, a program-load port and a
// ready/valid fetch port with 1-cycle latency and fault reporting.
module imem_fetch_port
  import riscv_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 64,
  parameter logic [XLEN-1:0] INIT_WORD = RV_NOP
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     init_done,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [XLEN-1:0]          prog_data,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [XLEN-1:0]          req_pc,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [XLEN-1:0]          rsp_instr,
  output logic [1:0]               rsp_fault
);

  localparam int ADDR_W = $clog2(DEPTH);

  imem_state_t       state, state_next;
  logic [ADDR_W-1:0] clr_cnt;
  logic              clr_last;
  imem_fault_t       req_fault;
  imem_fault_t       rsp_fault_q;
  logic              accept;

  logic              sram_we;
  logic              sram_re;
  logic [ADDR_W-1:0] sram_addr;
  logic [XLEN-1:0]   sram_wdata;
  logic [XLEN-1:0]   sram_rdata;

  assign clr_last = (clr_cnt == ADDR_W'(DEPTH - 1));
  assign accept   = req_valid & req_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_INIT;
    else       state <= state_next;
  end

  // Next state: the clear runs once per reset, then the port stays in S_RUN.
  always_comb begin
    state_next = state;
    case (state)
      S_INIT:  if (clr_last) state_next = S_RUN;
      S_RUN:   state_next = S_RUN;
      default: state_next = S_INIT;
    endcase
  end

  // Outputs and memory port steering; a load wins over a fetch.
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    init_done  = 1'b0;
    req_ready  = 1'b0;
    sram_we    = 1'b0;
    sram_re    = 1'b0;
    sram_addr  = req_pc[ADDR_W+1:2];
    sram_wdata = prog_data;
    case (state)
      S_INIT: begin
        sram_we    = 1'b1;
        sram_addr  = clr_cnt;
        sram_wdata = INIT_WORD;
      end
      S_RUN: begin
        init_done = 1'b1;
        req_ready = !prog_we && (!rsp_valid || rsp_ready);
        if (prog_we) begin
          sram_we   = 1'b1;
          sram_addr = prog_addr;
        end
        sram_re = req_valid && req_ready && (req_fault == FAULT_NONE);
      end
      default: ;
    endcase
  end

  // Fault decode on the request PC; misalignment outranks range.
  always_comb begin
    req_fault = FAULT_NONE;
    if (req_pc[1:0] != 2'b00)                 req_fault = FAULT_MISALIGN;
    else if ((req_pc >> (ADDR_W + 2)) != '0)  req_fault = FAULT_RANGE;
  end

  // Clear counter walks every word once while in S_INIT.
  always_ff @(posedge clk) begin
    if (reset)                 clr_cnt <= '0;
    else if (state == S_INIT)  clr_cnt <= clr_cnt + 1'b1;
  end

  // Response register: loaded on accept, dropped when consumed, held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid   <= 1'b0;
      rsp_fault_q <= FAULT_NONE;
    end else if (accept) begin
      rsp_valid   <= 1'b1;
      rsp_fault_q <= req_fault;
    end else if (rsp_ready) begin
      rsp_valid   <= 1'b0;
    end
  end

  assign rsp_fault = rsp_fault_q;
  assign rsp_instr = (rsp_fault_q != FAULT_NONE) ? INIT_WORD : sram_rdata;

  imem_sram #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_sram (
    .clk  (clk),
    .reset(reset),
    .we   (sram_we),
    .re   (sram_re),
    .addr (sram_addr),
    .wdata(sram_wdata),
    .rdata(sram_rdata)
  );

endmodule

// File: tb/tb_imem_fetch_port.sv
// Directed bench for imem_fetch_port (DEPTH=64): clear timing, loads,
// fetches with faults, backpressure streaming, load/fetch collision, resets.
module tb_imem_fetch_port;

  localparam int XLEN  = 32;
  localparam int DEPTH = 64;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            reset;
  logic            init_done;
  logic            prog_we;
  logic [5:0]      prog_addr;
  logic [31:0]     prog_data;
  logic            req_valid;
  logic            req_ready;
  logic [31:0]     req_pc;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_instr;
  logic [1:0]      rsp_fault;

  int checks   = 0;
  int failures = 0;

  imem_fetch_port #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .init_done(init_done),
    .prog_we  (prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_pc   (req_pc),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr),
    .rsp_fault(rsp_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  fault;
  } fetch_vec_t;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } load_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges from reset release until init_done (bounded).
  task automatic wait_init(input string name);
    int cnt;
    cnt = 0;
    while (!init_done && cnt < 200) begin
      tick();
      cnt++;
    end
    check(name, cnt, 64);
  endtask

  task automatic load(input logic [5:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic fetch(input string name, input logic [31:0] pc,
                       input logic [31:0] exp_instr, input logic [1:0] exp_fault);
    req_valid = 1'b1; req_pc = pc;
    #1;
    check({name, " req_ready"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({name, " instr"}, rsp_instr, exp_instr);
    check({name, " fault"}, 32'(rsp_fault), 32'(exp_fault));
  endtask

  initial begin
    fetch_vec_t fv[9];
    load_vec_t  lv[5];
    logic [31:0] exp_stream[4];
    logic [31:0] held_instr;
    logic [1:0]  held_fault;
    logic        was_stalled;
    int          issued, got;

    lv[0] = '{6'd3,  32'h0050_0093};
    lv[1] = '{6'd0,  32'h0010_0113};
    lv[2] = '{6'd1,  32'h0020_0193};
    lv[3] = '{6'd2,  32'h0030_0213};
    lv[4] = '{6'd63, 32'hDEAD_BEEF};

    fv[0] = '{32'h0000_000C, 32'h0050_0093, 2'b00};
    fv[1] = '{32'h0000_0000, 32'h0010_0113, 2'b00};
    fv[2] = '{32'h0000_00FC, 32'hDEAD_BEEF, 2'b00};
    fv[3] = '{32'h0000_0008, 32'h0030_0213, 2'b00};
    fv[4] = '{32'h0000_0006, NOP,           2'b01};
    fv[5] = '{32'h0000_0100, NOP,           2'b10};
    fv[6] = '{32'h0000_0102, NOP,           2'b01};
    fv[7] = '{32'h8000_0000, NOP,           2'b10};
    fv[8] = '{32'h0000_00FF, NOP,           2'b01};

    exp_stream[0] = 32'h0010_0113;
    exp_stream[1] = 32'h0020_0193;
    exp_stream[2] = 32'h0030_0213;
    exp_stream[3] = 32'h0050_0093;

    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    req_valid = 1'b0; req_pc = '0; rsp_ready = 1'b1;
    tick(); tick();

    // Reset state
    check("reset init_done", 32'(init_done), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_instr", rsp_instr, 32'd0);
    check("reset rsp_fault", 32'(rsp_fault), 32'd0);
    check("reset req_ready", 32'(req_ready), 32'd0);

    // 1: clear takes exactly DEPTH cycles; requests ignored during it
    reset = 1'b0;
    req_valid = 1'b1; req_pc = 32'h0;
    #1;
    check("clear req_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    wait_init("clear cycles");
    check("clear no rsp", 32'(rsp_valid), 32'd0);
    fetch("cleared 0xFC", 32'h0000_00FC, NOP, 2'b00);

    // 2: read-after-load on the very next cycle, response drops when consumed
    load(6'd3, 32'h0050_0093);
    fetch("ral 0x00C", 32'h0000_000C, 32'h0050_0093, 2'b00);
    tick();
    check("ral rsp drop", 32'(rsp_valid), 32'd0);

    // Table: remaining loads then single fetches including fault cases
    foreach (lv[i]) load(lv[i].addr, lv[i].data);
    foreach (fv[i]) begin
      fetch($sformatf("vec%0d", i), fv[i].pc, fv[i].instr, fv[i].fault);
      tick();
    end

    // 4: back-to-back stream with a 3-cycle stall
    issued = 0; got = 0; was_stalled = 1'b0;
    held_instr = '0; held_fault = '0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      req_valid = (issued < 4);
      req_pc    = 32'(issued * 4);
      rsp_ready = !(c >= 2 && c < 5);
      #1;
      if (was_stalled) begin
        check("stall instr held", rsp_instr, held_instr);
        check("stall fault held", 32'(rsp_fault), 32'(held_fault));
      end
      if (rsp_valid && !rsp_ready) begin
        check("stall req_ready", 32'(req_ready), 32'd0);
        was_stalled = 1'b1;
        held_instr  = rsp_instr;
        held_fault  = rsp_fault;
      end else begin
        was_stalled = 1'b0;
      end
      if (rsp_valid && rsp_ready) begin
        check($sformatf("stream word%0d", got), rsp_instr, exp_stream[got]);
        got++;
      end
      if (req_valid && req_ready) issued++;
      tick();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    check("stream count", 32'(got), 32'd4);
    check("stream issued", 32'(issued), 32'd4);
    tick();
    check("stream drained", 32'(rsp_valid), 32'd0);

    // 5: load and fetch collide; load wins, fetch follows with new data
    prog_we = 1'b1; prog_addr = 6'd5; prog_data = 32'h0060_0293;
    req_valid = 1'b1; req_pc = 32'h0000_0014;
    #1;
    check("collide req_ready", 32'(req_ready), 32'd0);
    tick();
    prog_we = 1'b0;
    check("collide no rsp", 32'(rsp_valid), 32'd0);
    fetch("collide fetch", 32'h0000_0014, 32'h0060_0293, 2'b00);
    tick();

    // 6a: reset with a response pending
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_pc = 32'h0000_0000;
    tick();
    req_valid = 1'b0;
    check("pending rsp_valid", 32'(rsp_valid), 32'd1);
    reset = 1'b1;
    tick();
    check("pending dropped", 32'(rsp_valid), 32'd0);
    check("pending init_done", 32'(init_done), 32'd0);
    reset = 1'b0; rsp_ready = 1'b1;

    // 6b: reset mid-clear restarts the full clear
    for (int i = 0; i < 20; i++) tick();
    check("midclear init_done", 32'(init_done), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_init("reclear cycles");
    fetch("recleared 0x00C", 32'h0000_000C, NOP, 2'b00);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
